// File: rtl/traffic_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_seq
// Brief    : N-phase traffic-light sequencer (GREEN/YELLOW/ALLRED) with night
//            flash, per-phase green times and key-driven time setting.
// Revision : 1.0
// ============================================================================
module traffic_phase_seq #(
    parameter int N_PHASE    = 4,
    parameter int CNT_W      = 11,
    parameter int GREEN_DEF  = 8,
    parameter int YELLOW_DEF = 6,
    parameter int ALLRED_DEF = 1,
    parameter int PH_W       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [1:0]         mode,
    input  logic               key_plus,
    input  logic               key_sub,
    input  logic [PH_W-1:0]    set_sel,
    input  logic [N_PHASE-1:0] phase_en,
    output logic [N_PHASE-1:0] lamp_r,
    output logic [N_PHASE-1:0] lamp_y,
    output logic [N_PHASE-1:0] lamp_g,
    output logic [PH_W-1:0]    cur_phase,
    output logic [1:0]         stage,
    output logic [CNT_W-1:0]   remain,
    output logic [CNT_W-1:0]   set_val
);

    localparam logic [1:0] c_ST_GREEN  = 2'b00;
    localparam logic [1:0] c_ST_YELLOW = 2'b01;
    localparam logic [1:0] c_ST_ALLRED = 2'b10;
    localparam logic [1:0] c_ST_NIGHT  = 2'b11;

    localparam logic [1:0] c_MODE_RUN   = 2'b00;
    localparam logic [1:0] c_MODE_NIGHT = 2'b01;
    localparam logic [1:0] c_MODE_SET_G = 2'b10;
    localparam logic [1:0] c_MODE_SET_Y = 2'b11;

    localparam logic [CNT_W-1:0] c_GREEN_DEF  = CNT_W'(GREEN_DEF);
    localparam logic [CNT_W-1:0] c_YELLOW_DEF = CNT_W'(YELLOW_DEF);
    localparam logic [CNT_W-1:0] c_ALLRED_DEF = CNT_W'(ALLRED_DEF);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [PH_W-1:0]  c_LAST_PHASE = PH_W'(N_PHASE - 1);

    logic [1:0]       r_stage;
    logic [PH_W-1:0]  r_phase;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] r_green [N_PHASE];
    logic [CNT_W-1:0] r_yellow;
    logic             r_flash;
    logic [CNT_W-1:0] r_set_val;

    logic [PH_W-1:0]  w_up_phase;
    logic [PH_W-1:0]  w_wrap_phase;
    logic             w_up_found;
    logic [PH_W-1:0]  w_next_phase;
    logic             w_sel_ok;
    logic [CNT_W-1:0] w_edit_cur;
    logic [CNT_W-1:0] w_edit_new;
    logic [N_PHASE-1:0] w_lamp_r;
    logic [N_PHASE-1:0] w_lamp_y;
    logic [N_PHASE-1:0] w_lamp_g;

    // Lowest enabled phase above the current one, else lowest enabled overall
    // (which may be the current phase itself).
    always_comb begin
        w_up_phase   = r_phase;
        w_wrap_phase = r_phase;
        w_up_found   = 1'b0;
        for (int i = N_PHASE - 1; i >= 0; i--) begin
            if (phase_en[i]) begin
                w_wrap_phase = PH_W'(i);
                if (i > int'(r_phase)) begin
                    w_up_phase = PH_W'(i);
                    w_up_found = 1'b1;
                end
            end
        end
        w_next_phase = w_up_found ? w_up_phase : w_wrap_phase;
    end

    assign w_sel_ok = (int'(set_sel) < N_PHASE);

    always_comb begin
        w_edit_cur = '0;
        if (mode == c_MODE_SET_Y) begin
            w_edit_cur = r_yellow;
        end else if (w_sel_ok) begin
            w_edit_cur = r_green[set_sel];
        end
        w_edit_new = w_edit_cur;
        if (key_plus && !key_sub && (w_edit_cur != c_CNT_MAX)) begin
            w_edit_new = w_edit_cur + c_ONE;
        end else if (key_sub && !key_plus && (w_edit_cur > c_ONE)) begin
            w_edit_new = w_edit_cur - c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage   <= c_ST_ALLRED;
            r_phase   <= c_LAST_PHASE;
            r_remain  <= c_ALLRED_DEF;
            r_yellow  <= c_YELLOW_DEF;
            r_flash   <= 1'b0;
            r_set_val <= '0;
            for (int i = 0; i < N_PHASE; i++) begin
                r_green[i] <= c_GREEN_DEF;
            end
        end else begin
            r_set_val <= '0;
            if (mode == c_MODE_NIGHT) begin
                r_stage  <= c_ST_NIGHT;
                r_remain <= '0;
                if (tick) begin
                    r_flash <= ~r_flash;
                end
            end else if (r_stage == c_ST_NIGHT) begin
                // Restart from the last phase so the search lands on the lowest enabled one.
                r_stage  <= c_ST_ALLRED;
                r_remain <= c_ALLRED_DEF;
                r_phase  <= c_LAST_PHASE;
                r_flash  <= 1'b0;
            end else if ((mode == c_MODE_RUN) && tick) begin
                if (r_remain > c_ONE) begin
                    r_remain <= r_remain - c_ONE;
                end else begin
                    case (r_stage)
                        c_ST_GREEN: begin
                            r_stage  <= c_ST_YELLOW;
                            r_remain <= r_yellow;
                        end
                        c_ST_YELLOW: begin
                            r_stage  <= c_ST_ALLRED;
                            r_remain <= c_ALLRED_DEF;
                        end
                        default: begin
                            if (|phase_en) begin
                                r_stage  <= c_ST_GREEN;
                                r_phase  <= w_next_phase;
                                r_remain <= r_green[w_next_phase];
                            end else begin
                                r_remain <= c_ALLRED_DEF;
                            end
                        end
                    endcase
                end
            end

            if (mode == c_MODE_SET_G) begin
                if (w_sel_ok) begin
                    r_green[set_sel] <= w_edit_new;
                    r_set_val        <= w_edit_new;
                end
            end else if (mode == c_MODE_SET_Y) begin
                r_yellow  <= w_edit_new;
                r_set_val <= w_edit_new;
            end
        end
    end

    always_comb begin
        w_lamp_r = '1;
        w_lamp_y = '0;
        w_lamp_g = '0;
        case (r_stage)
            c_ST_GREEN: begin
                w_lamp_r[r_phase] = 1'b0;
                w_lamp_g[r_phase] = 1'b1;
            end
            c_ST_YELLOW: begin
                w_lamp_r[r_phase] = 1'b0;
                w_lamp_y[r_phase] = 1'b1;
            end
            c_ST_NIGHT: begin
                w_lamp_r = '0;
                w_lamp_y = {N_PHASE{r_flash}};
            end
            default: ;
        endcase
    end

    assign lamp_r    = w_lamp_r;
    assign lamp_y    = w_lamp_y;
    assign lamp_g    = w_lamp_g;
    assign cur_phase = r_phase;
    assign stage     = r_stage;
    assign remain    = r_remain;
    assign set_val   = r_set_val;

endmodule
`default_nettype wire

// File: doc/traffic_phase_seq.md
Name: traffic_phase_seq

Overview:
- Parametrised N-phase traffic-light sequencer; successor to the fixed two-group (plus left-turn) controller in the same design.
- Cycles enabled phases through GREEN -> YELLOW -> ALLRED, with per-phase green times, a shared yellow time and a shared all-red clearance time.
- Provides night yellow-flash mode and key-driven time setting; phases can be skipped via an enable mask.
- Sits between the 1 s tick generator / key edge detectors and the lamp drivers / 7-segment count display.

Parameters:
N_PHASE, 4, number of signal phases (2..8)
CNT_W, 11, width of all time counters and settings
GREEN_DEF, 8, reset green time of every phase (ticks)
YELLOW_DEF, 6, reset yellow time (ticks)
ALLRED_DEF, 1, all-red clearance time (ticks, fixed, not settable)
PH_W, 2, width of phase index (ceil(log2(N_PHASE)), minimum 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse per second
mode  in  2  00 run, 01 night, 10 set green, 11 set yellow
key_plus  in  1  one-cycle increment pulse
key_sub  in  1  one-cycle decrement pulse
set_sel  in  PH_W  phase whose green time is edited in mode 10
phase_en  in  N_PHASE  per-phase enable mask; 0 = skip phase
lamp_r  out  N_PHASE  red per phase
lamp_y  out  N_PHASE  yellow per phase
lamp_g  out  N_PHASE  green per phase
cur_phase  out  PH_W  active phase index
stage  out  2  00 GREEN, 01 YELLOW, 10 ALLRED, 11 NIGHT
remain  out  CNT_W  ticks left in current stage
set_val  out  CNT_W  value being edited (green[set_sel] in 10, yellow in 11, else 0)

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising clk edge.
- Reset values:
  - stage = ALLRED, cur_phase = N_PHASE-1, remain = ALLRED_DEF.
  - All green[i] = GREEN_DEF, yellow = YELLOW_DEF, flash = 0, set_val = 0.
  - Lamps: all red.
- Reset has priority over every other input.
- Lamp outputs are combinational decodes of the registered stage/cur_phase/flash:
  - GREEN: lamp_g[cur_phase] = 1, all other phases red.
  - YELLOW: lamp_y[cur_phase] = 1, all other phases red.
  - ALLRED: all red.
  - NIGHT: lamp_y = {N_PHASE{flash}}; red and green all 0.
- Countdown (run mode, stage != NIGHT):
  - On tick with remain > 1: remain decrements.
  - On tick with remain == 1: stage transition; remain loads the new stage's duration in the same cycle.
  - A stage of duration D therefore lasts exactly D ticks.
- Transitions:
  - GREEN -> YELLOW, remain = yellow.
  - YELLOW -> ALLRED, remain = ALLRED_DEF.
  - ALLRED -> GREEN of the next enabled phase, searching upward from cur_phase+1 with wrap modulo N_PHASE; remain = green[next].
  - cur_phase itself is a valid candidate (found last), so a single enabled phase repeats.
- phase_en == 0 at the ALLRED expiry: stay in ALLRED, remain reloads ALLRED_DEF.
- phase_en is sampled only at ALLRED expiry; disabling the active phase mid-GREEN has no immediate effect.
- Night (mode 01), taking effect the next cycle from any stage:
  - stage = NIGHT, remain = 0; flash toggles on each tick.
- Leaving night (mode != 01 while stage == NIGHT):
  - stage = ALLRED, remain = ALLRED_DEF, cur_phase = N_PHASE-1, flash = 0.
  - Next green is the lowest enabled phase.
- Set modes (10, 11):
  - tick is ignored; stage, remain and lamps freeze.
  - Mode 10 edits green[set_sel]; mode 11 edits yellow.
  - key_plus: +1, saturating at 2^CNT_W-1. key_sub: -1, saturating at 1.
  - key_plus and key_sub in the same cycle: no change.
- Edited values apply at the next load of that stage; the current remain is never altered.
- Simultaneous tick and mode change: the mode sampled in that cycle governs; a tick in a set mode is lost.
- set_val is registered, one cycle latency after the edit or select change.
- set_sel >= N_PHASE: edits ignored, set_val = 0.

Test Plan:
- Reset, mode=00, phase_en=4'b1111, defaults:
  - 1 tick -> phase0 GREEN, remain=8.
  - 8 ticks -> YELLOW, remain=6.
  - 6 ticks -> ALLRED, remain=1.
  - 1 tick -> phase1 GREEN; lamp_g=0001 then 0010.
- phase_en=4'b0101 -> greens alternate phase0, phase2; phases 1 and 3 never green. phase_en=0 -> stays ALLRED indefinitely, lamp_r=1111.
- mode=01 mid-GREEN -> next cycle stage=NIGHT, lamp_g=0; 4 ticks -> lamp_y toggles 1111/0000 twice. Return to 00 -> ALLRED 1 tick, then phase0 GREEN.
- mode=10, set_sel=2:
  - 3 key_plus -> set_val=11.
  - 20 key_sub -> set_val saturates at 1.
  - key_plus+key_sub together -> unchanged.
  - Ticks during editing -> remain frozen.
  - Back in run -> phase2 green lasts 1 tick.
- mode=11 with yellow=6, key_plus while phase0 is in YELLOW with remain=3 -> remain stays 3; the next YELLOW loads 7.
- Assert rst mid-YELLOW with edited settings -> next cycle stage=ALLRED, cur_phase=3, remain=1, green[*]=8, yellow=6.
